cp0_ctrl: RTL and testbench
===========================

# cp0_ctrl

Parametrised coprocessor-0 block for the MIPS32 core, succeeding the fixed-function CP0 register file. It holds BadVAddr, Count, Compare, Status, Cause and EPC, and samples a configurable number of hardware interrupt lines. It generates the interrupt request and flush/redirect signals for the pipeline, and records exception state. It sits beside the MEM/WB boundary, with mfc0/mtc0 access from the pipeline.

## Interface
Parameters:
- NUM_HW_INT, 6, hardware interrupt lines (1..6), mapped to Cause.IP[2 +: NUM_HW_INT]
- COUNT_DIV, 2, clock cycles per Count increment (≥1)
- INT_VECTOR, 32'h0000_0040, redirect address for exccode 5'h00 (interrupt)
- EXC_VECTOR, 32'h0000_0100, redirect address for all other exceptions

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- we  in  1  mtc0 write enable
- waddr  in  5  mtc0 register number
- wdata  in  32  mtc0 data
- re  in  1  mfc0 read enable
- raddr  in  5  mfc0 register number
- data_o  out  32  mfc0 read data
- int_i  in  NUM_HW_INT  level-sensitive hardware interrupts
- pc_i  in  32  PC of the excepting instruction
- in_delay_i  in  1  excepting instruction is in a delay slot
- exccode_i  in  5  5'h10 = none, 5'h11 = eret, else exception code
- badaddr_i  in  32  faulting address for AdEL/AdES
- int_req_o  out  1  interrupt pending and enabled
- flush  out  1  pipeline flush (combinational)
- flush_im  out  1  flush registered by one cycle
- cp0_excaddr  out  32  redirect target, registered
- status_o, cause_o, epc_o  out  32 each  live register values

## Operation
- Register map: 8 BadVAddr (read-only), 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Unmapped reads return 0. data_o is 0 when re=0 or in reset.
- Cause is writable only at bits [9:8] (software IP1:0). Status, EPC, Count and Compare are writable in full.
- Cause.IP[7:2] are resampled every cycle from int_i. Bits above NUM_HW_INT read 0. Cause[15] = int_i[5] OR Cause.TI.
- int_req_o = Status.IE(0) & ~Status.EXL(1) & |(Status.IM[15:8] & Cause.IP[15:8]). Combinational from registers.
- Exception (exccode_i ∉ {10,11}):
  - If EXL=0: EPC = in_delay_i ? pc_i−4 : pc_i, and Cause.BD = in_delay_i.
  - If EXL=1: EPC and BD are unchanged.
  - Always: EXL=1 and Cause.ExcCode[6:2] = exccode_i.
  - For exccode 5'h04/5'h05: BadVAddr = badaddr_i.
  - A concurrent mtc0 is dropped.
- eret (5'h11): EXL cleared. A concurrent mtc0 is performed.
- flush = rst_n & (exccode_i != 5'h10).
- cp0_excaddr next value:
  - INT_VECTOR for code 0.
  - For eret: wdata when (we & waddr==14), else EPC.
  - EXC_VECTOR for other exceptions.
  - 0 when there is no exception.

## Timing
- Reset, asynchronous, all outputs and registers:
  - Status = 32'h1000_0000.
  - All other registers 0, including the prescaler.
  - flush_im = 0 and cp0_excaddr = 0.
- mtc0 takes effect at the next rising edge. mfc0 is combinational on current register state.
- flush_im and cp0_excaddr are valid exactly one cycle after flush.
- Count and the prescaler are described under Configuration (timer logic).

## Configuration
- CP0_TIMER_EN defined:
  - Prescaler counts 0..COUNT_DIV−1. Count increments on the wrap, and wraps at 2^32.
  - An mtc0 to Count loads wdata, resets the prescaler, and overrides that cycle's increment.
  - When the post-increment Count == Compare, Cause.TI(30) is set.
  - An mtc0 to Compare clears TI. If a set and a clear occur in the same cycle, the clear wins.
  - TI feeds IP7 via Cause[15].
- CP0_TIMER_EN undefined:
  - Count, Compare and TI read 0, and writes to them are ignored.
  - No prescaler logic is built.
  - Cause[15] = int_i[5] only.

## Test plan
- Reset mid-run with rst_n=0 → data_o(12)=32'h1000_0000, cp0_excaddr=0, int_req_o=0, without waiting for a clock edge.
- Status=32'h0000_8401, int_i[0]=1 → int_req_o=1. Then exccode 0, pc_i=32'h200, in_delay_i=1 → flush=1; next cycle EPC=32'h1FC, BD=1, EXL=1, cp0_excaddr=32'h040, int_req_o=0.
- Nested exception with EXL=1, exccode 5'h04, pc_i=32'h300, badaddr_i=32'h1003 → EPC unchanged, BadVAddr=32'h1003, ExcCode=4, cp0_excaddr=32'h100.
- eret with concurrent mtc0 EPC=32'h500 → cp0_excaddr=32'h500 next cycle, EXL=0. eret without a write → EPC value.
- CP0_TIMER_EN, COUNT_DIV=2, Compare=5, Count=0, IM7 and IE set → TI and int_req_o rise after 10 cycles. mtc0 Compare clears TI the next cycle.
- mtc0 Cause with 32'hFFFF_FFFF → only bits [9:8] change. With Status.IM0 and IE set, int_req_o=1.

Source files
------------

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 control: BadVAddr/Count/Compare/Status/Cause/EPC, interrupt request, flush and redirect.
// Optional timer (Count/Compare/TI and prescaler) is built only when CP0_TIMER_EN is defined.
module cp0_ctrl #(
    parameter int          NUM_HW_INT = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] INT_VECTOR = 32'h0000_0040,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [4:0]            waddr,
    input  logic [31:0]           wdata,
    input  logic                  re,
    input  logic [4:0]            raddr,
    output logic [31:0]           data_o,
    input  logic [NUM_HW_INT-1:0] int_i,
    input  logic [31:0]           pc_i,
    input  logic                  in_delay_i,
    input  logic [4:0]            exccode_i,
    input  logic [31:0]           badaddr_i,
    output logic                  int_req_o,
    output logic                  flush,
    output logic                  flush_im,
    output logic [31:0]           cp0_excaddr,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o
);
    localparam logic [4:0] EXC_NONE = 5'h10;
    localparam logic [4:0] EXC_ERET = 5'h11;

    logic [31:0] r_badvaddr, r_status, r_epc, r_excaddr;
    logic [5:0]  r_ip_hw;
    logic [1:0]  r_ip_sw;
    logic        r_bd;
    logic [4:0]  r_exccode;
    logic        r_flush_im;
    logic [31:0] w_count, w_compare, w_cause, w_excaddr_nxt;
    logic        w_ti, w_exc, w_eret, w_wr;
    logic [5:0]  w_int_pad;

    assign w_exc     = (exccode_i != EXC_NONE) && (exccode_i != EXC_ERET);
    assign w_eret    = (exccode_i == EXC_ERET);
    // An exception in the same cycle swallows the mtc0.
    assign w_wr      = we & ~w_exc;
    assign w_int_pad = 6'(int_i);

`ifdef CP0_TIMER_EN
    localparam int            PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [31:0]   r_count, r_compare;
    logic          r_ti;
    logic          w_tick, w_count_wr, w_cmp_wr;
    logic [31:0]   w_count_inc;

    assign w_tick      = (r_presc == PRESC_MAX);
    assign w_count_inc = r_count + 32'd1;
    assign w_count_wr  = w_wr & (waddr == 5'd9);
    assign w_cmp_wr    = w_wr & (waddr == 5'd11);

    // Prescaler, Count, Compare and the timer interrupt flag (Compare write beats a same-cycle match).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_ti      <= 1'b0;
        end else begin
            if (w_count_wr) begin
                r_count <= wdata;
                r_presc <= '0;
            end else begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
                if (w_tick) r_count <= w_count_inc;
            end
            if (w_cmp_wr) begin
                r_compare <= wdata;
                r_ti      <= 1'b0;
            end else if (w_tick && !w_count_wr && (w_count_inc == r_compare)) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign w_count   = r_count;
    assign w_compare = r_compare;
    assign w_ti      = r_ti;
`else
    assign w_count   = 32'd0;
    assign w_compare = 32'd0;
    assign w_ti      = 1'b0;
`endif

    assign w_cause = {r_bd, w_ti, 14'd0, r_ip_hw[5] | w_ti, r_ip_hw[4:0], r_ip_sw,
                      1'b0, r_exccode, 2'b00};

    // Redirect target to be registered alongside the flush.
    always_comb begin
        w_excaddr_nxt = 32'd0;
        if (exccode_i == 5'h00) begin
            w_excaddr_nxt = INT_VECTOR;
        end else if (w_eret) begin
            w_excaddr_nxt = (we && (waddr == 5'd14)) ? wdata : r_epc;
        end else if (w_exc) begin
            w_excaddr_nxt = EXC_VECTOR;
        end else begin
            w_excaddr_nxt = 32'd0;
        end
    end

    // Architectural state: mtc0 writes, exception entry and eret.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_badvaddr <= 32'd0;
            r_status   <= 32'h1000_0000;
            r_epc      <= 32'd0;
            r_excaddr  <= 32'd0;
            r_ip_hw    <= 6'd0;
            r_ip_sw    <= 2'd0;
            r_bd       <= 1'b0;
            r_exccode  <= 5'd0;
            r_flush_im <= 1'b0;
        end else begin
            r_ip_hw    <= w_int_pad;
            r_flush_im <= (exccode_i != EXC_NONE);
            r_excaddr  <= w_excaddr_nxt;
            if (w_wr) begin
                case (waddr)
                    5'd12:   r_status <= wdata;
                    5'd13:   r_ip_sw  <= wdata[9:8];
                    5'd14:   r_epc    <= wdata;
                    default: ;
                endcase
            end
            if (w_exc) begin
                if (!r_status[1]) begin
                    r_epc <= in_delay_i ? pc_i - 32'd4 : pc_i;
                    r_bd  <= in_delay_i;
                end
                r_status[1] <= 1'b1;
                r_exccode   <= exccode_i;
                if ((exccode_i == 5'h04) || (exccode_i == 5'h05)) r_badvaddr <= badaddr_i;
            end else if (w_eret) begin
                // Placed after the mtc0 so eret still clears EXL over a Status write.
                r_status[1] <= 1'b0;
            end
        end
    end

    // mfc0 read mux.
    always_comb begin
        data_o = 32'd0;
        if (rst_n && re) begin
            case (raddr)
                5'd8:    data_o = r_badvaddr;
                5'd9:    data_o = w_count;
                5'd11:   data_o = w_compare;
                5'd12:   data_o = r_status;
                5'd13:   data_o = w_cause;
                5'd14:   data_o = r_epc;
                default: data_o = 32'd0;
            endcase
        end else begin
            data_o = 32'd0;
        end
    end

    assign int_req_o   = r_status[0] & ~r_status[1] & (|(r_status[15:8] & w_cause[15:8]));
    assign flush       = rst_n & (exccode_i != EXC_NONE);
    assign flush_im    = r_flush_im;
    assign cp0_excaddr = r_excaddr;
    assign status_o    = r_status;
    assign cause_o     = w_cause;
    assign epc_o       = r_epc;
endmodule

// File: tb/tb_cp0_ctrl.sv
// Scoreboard bench for cp0_ctrl: directed scenarios plus random traffic against a register-array model.
module tb_cp0_ctrl;
    localparam int          NHW     = 6;
    localparam int          DIV     = 2;
    localparam logic [31:0] INT_VEC = 32'h0000_0040;
    localparam logic [31:0] EXC_VEC = 32'h0000_0100;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           we, re, in_delay_i, int_req_o, flush, flush_im;
    logic [4:0]     waddr, raddr, exccode_i;
    logic [31:0]    wdata, data_o, pc_i, badaddr_i, cp0_excaddr, status_o, cause_o, epc_o;
    logic [NHW-1:0] int_i;

    always #5 clk = ~clk;

    cp0_ctrl #(.NUM_HW_INT(NHW), .COUNT_DIV(DIV), .INT_VECTOR(INT_VEC), .EXC_VECTOR(EXC_VEC)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .re(re), .raddr(raddr),
        .data_o(data_o), .int_i(int_i), .pc_i(pc_i), .in_delay_i(in_delay_i), .exccode_i(exccode_i),
        .badaddr_i(badaddr_i), .int_req_o(int_req_o), .flush(flush), .flush_im(flush_im),
        .cp0_excaddr(cp0_excaddr), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o));

    typedef struct {
        logic we; logic [4:0] waddr; logic [31:0] wdata; logic re; logic [4:0] raddr;
        logic [NHW-1:0] intv; logic [31:0] pc; logic dly; logic [4:0] code; logic [31:0] bad;
    } stim_t;
    typedef struct {
        int cyc; logic [31:0] data, status, cause, epc, excaddr; logic intreq, flush, flush_im;
    } exp_t;

    exp_t        sbq[$];
    int          n_chk = 0, n_fail = 0, cyc = 0;
    logic [31:0] m_r [0:31];
    logic [5:0]  m_hw;
    int          m_presc;
    logic [31:0] m_excaddr;
    logic        m_flush_im;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input int c);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, c, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_r[i] = 32'd0;
        m_r[12] = 32'h1000_0000;
        m_hw = 6'd0; m_presc = 0; m_excaddr = 32'd0; m_flush_im = 1'b0;
    endfunction

    function automatic logic [31:0] cause_rd();
        return m_r[13] | {16'd0, m_hw[5] | m_r[13][30], m_hw[4:0], 10'd0};
    endfunction

    function automatic logic [31:0] rd(input logic [4:0] a);
        case (a)
            5'd8, 5'd9, 5'd11, 5'd12, 5'd14: return m_r[a];
            5'd13:   return cause_rd();
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic intreq();
        logic [31:0] s, c;
        s = m_r[12]; c = cause_rd();
        return s[0] & ~s[1] & (|(s[15:8] & c[15:8]));
    endfunction

    function automatic void model_step(input stim_t s);
        logic        exc, eret, wr;
        logic [31:0] nxt;
        exc  = (s.code != 5'h10) && (s.code != 5'h11);
        eret = (s.code == 5'h11);
        wr   = s.we && !exc;
        if (s.code == 5'h00)  nxt = INT_VEC;
        else if (eret)        nxt = (s.we && s.waddr == 5'd14) ? s.wdata : m_r[14];
        else if (exc)         nxt = EXC_VEC;
        else                  nxt = 32'd0;
`ifdef CP0_TIMER_EN
        if (wr && s.waddr == 5'd9) begin
            m_r[9] = s.wdata; m_presc = 0;
        end else begin
            m_presc++;
            if (m_presc == DIV) begin
                m_presc = 0;
                m_r[9] = m_r[9] + 32'd1;
                if (m_r[9] == m_r[11]) m_r[13][30] = 1'b1;
            end
        end
        if (wr && s.waddr == 5'd11) begin
            m_r[11] = s.wdata; m_r[13][30] = 1'b0;
        end
`endif
        if (wr) begin
            case (s.waddr)
                5'd12:   m_r[12] = s.wdata;
                5'd13:   m_r[13][9:8] = s.wdata[9:8];
                5'd14:   m_r[14] = s.wdata;
                default: ;
            endcase
        end
        if (exc) begin
            if (!m_r[12][1]) begin
                m_r[14] = s.dly ? s.pc - 32'd4 : s.pc;
                m_r[13][31] = s.dly;
            end
            m_r[12][1] = 1'b1;
            m_r[13][6:2] = s.code;
            if (s.code == 5'h04 || s.code == 5'h05) m_r[8] = s.bad;
        end else if (eret) begin
            m_r[12][1] = 1'b0;
        end
        m_hw = 6'(s.intv); m_excaddr = nxt; m_flush_im = (s.code != 5'h10);
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.we = 1'b0; s.waddr = 5'd0; s.wdata = 32'd0; s.re = 1'b0; s.raddr = 5'd0;
        s.intv = '0; s.pc = 32'd0; s.dly = 1'b0; s.code = 5'h10; s.bad = 32'd0;
        return s;
    endfunction

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 6))
            0: return 5'd8;  1: return 5'd9;  2: return 5'd11; 3: return 5'd12;
            4: return 5'd13; 5: return 5'd14;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        int    k;
        s.we = ($urandom_range(0, 2) == 0); s.waddr = pick_reg(); s.wdata = $urandom;
        s.re = 1'($urandom_range(0, 1)); s.raddr = pick_reg();
        s.intv = NHW'($urandom); s.pc = $urandom & 32'hFFFF_FFFC; s.dly = 1'($urandom_range(0, 1));
        s.bad = $urandom;
        k = $urandom_range(0, 9);
        if (k < 6)       s.code = 5'h10;
        else if (k == 6) s.code = 5'h11;
        else if (k == 7) s.code = 5'h00;
        else if (k == 8) s.code = 5'($urandom_range(4, 5));
        else             s.code = 5'($urandom_range(0, 31));
        return s;
    endfunction

    task automatic apply(input stim_t s);
        we = s.we; waddr = s.waddr; wdata = s.wdata; re = s.re; raddr = s.raddr;
        int_i = s.intv; pc_i = s.pc; in_delay_i = s.dly; exccode_i = s.code; badaddr_i = s.bad;
    endtask

    task automatic drive_cycle(input stim_t s);
        exp_t e;
        @(negedge clk);
        apply(s);
        #1;
        e.cyc = cyc; e.data = s.re ? rd(s.raddr) : 32'd0; e.status = m_r[12]; e.cause = cause_rd();
        e.epc = m_r[14]; e.excaddr = m_excaddr; e.intreq = intreq(); e.flush = (s.code != 5'h10);
        e.flush_im = m_flush_im;
        sbq.push_back(e);
        @(posedge clk);
        model_step(s);
        cyc++;
    endtask

    task automatic do_reset();
        exp_t  e;
        stim_t s;
        s = idle(); s.re = 1'b1; s.raddr = 5'd12;
        @(negedge clk);
        apply(s);
        exccode_i = 5'h04;
        rst_n = 1'b0;
        model_reset();
        #1;
        e.cyc = cyc; e.data = 32'd0; e.status = 32'h1000_0000; e.cause = 32'd0; e.epc = 32'd0;
        e.excaddr = 32'd0; e.intreq = 1'b0; e.flush = 1'b0; e.flush_im = 1'b0;
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        exccode_i = 5'h10;
        #3;
        rst_n = 1'b1;
        #1;
        chk("data_o_after_release", data_o, 32'h1000_0000, cyc);
        @(posedge clk);
        model_step(s);
        cyc++;
    endtask

    // Monitor: compare every queued expectation with the live outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("data_o", data_o, e.data, e.cyc);
                chk("status_o", status_o, e.status, e.cyc);
                chk("cause_o", cause_o, e.cause, e.cyc);
                chk("epc_o", epc_o, e.epc, e.cyc);
                chk("cp0_excaddr", cp0_excaddr, e.excaddr, e.cyc);
                chk("int_req_o", 32'(int_req_o), 32'(e.intreq), e.cyc);
                chk("flush", 32'(flush), 32'(e.flush), e.cyc);
                chk("flush_im", 32'(flush_im), 32'(e.flush_im), e.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        apply(idle());
        model_reset();
        do_reset();

        s = idle(); s.we = 1'b1; s.waddr = 5'd12; s.wdata = 32'h0000_8401; s.intv = 6'd1;
        drive_cycle(s);
        #1 chk("irq_enabled", 32'(int_req_o), 32'd1, cyc);

        s = idle(); s.intv = 6'd1; s.code = 5'h00; s.pc = 32'h200; s.dly = 1'b1;
        s.we = 1'b1; s.waddr = 5'd14; s.wdata = 32'hDEAD_BEEF;
        drive_cycle(s);
        #1;
        chk("exc_epc", epc_o, 32'h0000_01FC, cyc);
        chk("exc_cause", cause_o, 32'h8000_0400, cyc);
        chk("exc_exl", 32'(status_o[1]), 32'd1, cyc);
        chk("exc_vec", cp0_excaddr, 32'h0000_0040, cyc);
        chk("exc_irq_masked", 32'(int_req_o), 32'd0, cyc);

        s = idle(); s.code = 5'h04; s.pc = 32'h300; s.bad = 32'h1003; s.re = 1'b1; s.raddr = 5'd8;
        drive_cycle(s);
        #1;
        chk("nest_epc", epc_o, 32'h0000_01FC, cyc);
        chk("nest_badv", data_o, 32'h0000_1003, cyc);
        chk("nest_cause", cause_o, 32'h8000_0010, cyc);
        chk("nest_vec", cp0_excaddr, 32'h0000_0100, cyc);

        s = idle(); s.code = 5'h11; s.we = 1'b1; s.waddr = 5'd14; s.wdata = 32'h500;
        drive_cycle(s);
        #1;
        chk("eret_wr_vec", cp0_excaddr, 32'h0000_0500, cyc);
        chk("eret_status", status_o, 32'h0000_8401, cyc);

        s = idle(); s.we = 1'b1; s.waddr = 5'd14; s.wdata = 32'h640;
        drive_cycle(s);
        s = idle(); s.code = 5'h11;
        drive_cycle(s);
        #1 chk("eret_epc_vec", cp0_excaddr, 32'h0000_0640, cyc);

        s = idle(); s.we = 1'b1; s.waddr = 5'd12; s.wdata = 32'h0000_0101;
        drive_cycle(s);
        s = idle(); s.we = 1'b1; s.waddr = 5'd13; s.wdata = 32'hFFFF_FFFF;
        drive_cycle(s);
        #1;
        chk("cause_sw_only", cause_o, 32'h8000_0310, cyc);
        chk("irq_sw", 32'(int_req_o), 32'd1, cyc);

        s = idle(); s.we = 1'b1; s.waddr = 5'd9; s.wdata = 32'h1234; s.re = 1'b1; s.raddr = 5'd9;
        drive_cycle(s);
        s = idle(); s.re = 1'b1; s.raddr = 5'd9;
        drive_cycle(s);

        s = idle(); s.we = 1'b1; s.waddr = 5'd12; s.wdata = 32'h0000_8001;
        drive_cycle(s);
        s = idle(); s.we = 1'b1; s.waddr = 5'd11; s.wdata = 32'd5;
        drive_cycle(s);
        s = idle(); s.we = 1'b1; s.waddr = 5'd9; s.wdata = 32'd0;
        drive_cycle(s);
`ifdef CP0_TIMER_EN
        for (int i = 1; i <= 10; i++) begin
            drive_cycle(idle());
            #1;
            chk("timer_ti", 32'(cause_o[30]), (i == 10) ? 32'd1 : 32'd0, cyc);
            chk("timer_irq", 32'(int_req_o), (i == 10) ? 32'd1 : 32'd0, cyc);
        end
        s = idle(); s.we = 1'b1; s.waddr = 5'd11; s.wdata = 32'h100;
        drive_cycle(s);
        #1;
        chk("ti_clear", 32'(cause_o[30]), 32'd0, cyc);
        chk("ti_clear_irq", 32'(int_req_o), 32'd0, cyc);
`else
        for (int i = 1; i <= 10; i++) drive_cycle(idle());
`endif

        for (int i = 0; i < 400; i++) drive_cycle(rnd());
        do_reset();
        for (int i = 0; i < 60; i++) drive_cycle(rnd());

        repeat (2) @(negedge clk);
        #3;
        n_chk++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain cyc=%0d actual=%0d expected=0", cyc, sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
